// File: rtl/amdc_adc_serial_capture.sv
// amdc_adc_serial_capture
//   Front end of the ADC path. Drives CNV/SCK of an 8-lane simultaneous-sampling
//   serial ADC (LTC2320 class), shifts all SDO lanes in parallel and presents one
//   frame of NCH raw samples with a one-cycle valid strobe.
//
//   Optional build macro: ADC_TEST_PATTERN_EN
//     defined   -> adds input test_mode; when set at frame start, channel i of the
//                  frame is (frame_cnt + i) mod 2^NBITS instead of SDO data.
//     undefined -> data always comes from adc_sdo.
//
// Ports
//   ACLK           in   system clock (rising edge)
//   ARESETN        in   asynchronous active-low reset
//   enable         in   1 = triggers accepted, 0 = triggers ignored (and not counted)
//   trigger        in   single-cycle start-of-conversion request
//   sclk_div       in   SCK half-period = sclk_div+1 ACLK cycles, latched at frame start
//   clear_stats    in   synchronous clear of trig_drop_cnt
//   adc_sdo        in   NCH serial data lanes
//   test_mode      in   (ADC_TEST_PATTERN_EN only) test pattern select
//   adc_cnv        out  ADC convert strobe
//   adc_sck        out  ADC serial clock, idles low
//   data_out       out  channel i at [i*NBITS +: NBITS]
//   data_valid     out  one-cycle pulse, data_out updated on the same edge
//   busy           out  frame in progress
//   trig_drop_cnt  out  triggers seen while busy, saturating
module amdc_adc_serial_capture #(
  parameter int NCH         = 8,
  parameter int NBITS       = 16,
  parameter int CNV_HIGH    = 2,
  parameter int CONV_CYCLES = 30
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 enable,
  input  logic                 trigger,
  input  logic [7:0]           sclk_div,
  input  logic                 clear_stats,
  input  logic [NCH-1:0]       adc_sdo,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  output logic                 adc_cnv,
  output logic                 adc_sck,
  output logic [NCH*NBITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic [15:0]          trig_drop_cnt
);

  localparam int CMAX = (CNV_HIGH > CONV_CYCLES) ? CNV_HIGH : CONV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNV   = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;      // CNV-high / conversion-wait countdown
  logic [7:0]      phase_reg;    // position within the current SCK half-period
  logic            half_reg;     // 1 = high half of the SCK period, 0 = low half
  logic [BW-1:0]   bit_reg;      // completed SCK periods
  logic [7:0]      div_reg;      // sclk_div latched at frame start

  logic                 cnv_reg, sck_reg, dv_reg, busy_reg;
  logic                 cnv_next, sck_next, dv_next, busy_next;
  logic [NCH*NBITS-1:0] data_out_reg;
  logic [NCH*NBITS-1:0] frame_word;
  logic [15:0]          drop_cnt_reg;

  logic start;
  logic half_end;
  logic sample_now;
  logic drop;

  assign start    = (state_reg == S_IDLE) && trigger && enable;
  assign drop     = (state_reg != S_IDLE) && trigger && enable;
  assign half_end = (phase_reg == div_reg);
  // The pins are registered from the state one cycle later, so the edge that
  // drives adc_sck 1->0 is the first edge after the low half has begun.
  assign sample_now = (state_reg == S_SHIFT) && !half_reg && (phase_reg == 8'd0);

  // ---------------- state register ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_CNV;
      S_CNV:   if (cnt_reg == '0) state_next = S_WAIT;
      S_WAIT:  if (cnt_reg == '0) state_next = S_SHIFT;
      S_SHIFT: if (half_end && !half_reg && (bit_reg == BW'(NBITS - 1))) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- output logic (pins registered one cycle after state) ----------------
  always_comb begin
    cnv_next  = (state_reg == S_CNV);
    sck_next  = (state_reg == S_SHIFT) && half_reg;
    busy_next = (state_reg != S_IDLE);
    dv_next   = (state_reg == S_DONE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnv_reg  <= 1'b0;
      sck_reg  <= 1'b0;
      busy_reg <= 1'b0;
      dv_reg   <= 1'b0;
    end else begin
      cnv_reg  <= cnv_next;
      sck_reg  <= sck_next;
      busy_reg <= busy_next;
      dv_reg   <= dv_next;
    end
  end

  // ---------------- timing counters ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_reg   <= '0;
      phase_reg <= 8'd0;
      half_reg  <= 1'b0;
      bit_reg   <= '0;
      div_reg   <= 8'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            cnt_reg <= CW'(CNV_HIGH - 1);
            div_reg <= sclk_div;
          end
        end
        S_CNV: begin
          if (cnt_reg == '0) cnt_reg <= CW'(CONV_CYCLES - 1);
          else               cnt_reg <= cnt_reg - CW'(1);
        end
        S_WAIT: begin
          if (cnt_reg == '0) begin
            phase_reg <= 8'd0;
            half_reg  <= 1'b1;
            bit_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        S_SHIFT: begin
          if (half_end) begin
            phase_reg <= 8'd0;
            half_reg  <= ~half_reg;
            if (!half_reg) bit_reg <= bit_reg + BW'(1);
          end else begin
            phase_reg <= phase_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- test pattern support ----------------
`ifdef ADC_TEST_PATTERN_EN
  logic [NBITS-1:0] frame_cnt_reg;
  logic             tm_reg;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      frame_cnt_reg <= '0;
      tm_reg        <= 1'b0;
    end else begin
      if (start) tm_reg <= test_mode;
      // Pattern uses the pre-increment count of the frame being completed.
      if (state_reg == S_DONE) frame_cnt_reg <= frame_cnt_reg + NBITS'(1);
    end
  end
`endif

  // ---------------- per-lane shift registers ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      logic [NBITS-1:0] shift_reg;

      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          shift_reg <= '0;
        end else if (start) begin
          shift_reg <= '0;
        end else if (sample_now) begin
          shift_reg <= {shift_reg[NBITS-2:0], adc_sdo[gi]};
        end
      end

`ifdef ADC_TEST_PATTERN_EN
      assign frame_word[gi*NBITS +: NBITS] = tm_reg ? (frame_cnt_reg + NBITS'(gi)) : shift_reg;
`else
      assign frame_word[gi*NBITS +: NBITS] = shift_reg;
`endif
    end
  endgenerate

  // ---------------- frame output and drop statistics ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      data_out_reg <= '0;
      drop_cnt_reg <= 16'd0;
    end else begin
      // Whole frame is transferred in one edge, so data_out is never partial.
      if (state_reg == S_DONE) data_out_reg <= frame_word;
      if (clear_stats)                             drop_cnt_reg <= 16'd0;
      else if (drop && (drop_cnt_reg != 16'hFFFF)) drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign adc_cnv       = cnv_reg;
  assign adc_sck       = sck_reg;
  assign busy          = busy_reg;
  assign data_valid    = dv_reg;
  assign data_out      = data_out_reg;
  assign trig_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_amdc_adc_serial_capture.sv
// Testbench for amdc_adc_serial_capture: randomized frames checked every cycle
// against a timeline model (frame start edge, latched divider, expected words).
module tb_amdc_adc_serial_capture;
  localparam int NCH   = 8;
  localparam int NBITS = 16;
  localparam int CH    = 2;
  localparam int CC    = 30;
  localparam int DW    = NCH * NBITS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable, trigger, clear_stats;
  logic [7:0]      sclk_div;
  logic [NCH-1:0]  adc_sdo;
  logic            adc_cnv, adc_sck, data_valid, busy;
  logic [DW-1:0]   data_out;
  logic [15:0]     trig_drop_cnt;
`ifdef ADC_TEST_PATTERN_EN
  logic            test_mode;
`endif

  int checks = 0;
  int errors = 0;

  amdc_adc_serial_capture #(
    .NCH(NCH), .NBITS(NBITS), .CNV_HIGH(CH), .CONV_CYCLES(CC)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .enable(enable), .trigger(trigger),
    .sclk_div(sclk_div), .clear_stats(clear_stats), .adc_sdo(adc_sdo),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .adc_cnv(adc_cnv), .adc_sck(adc_sck), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .trig_drop_cnt(trig_drop_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int               edge_no = 0;
  bit               active  = 0;
  int               ks, dd, s0, dv_e;
  logic [NBITS-1:0] lane_w  [NCH];
  logic [NBITS-1:0] frame_w [NCH];
  logic [DW-1:0]    exp_data = '0;
  int               exp_drop = 0;
  logic [NBITS-1:0] fcnt = '0;
  bit               frame_tm = 0;

  function automatic bit model_busy(input int e);
    return active && (e >= ks + 1) && (e <= dv_e);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_no, obs, exp);
    end
  endtask

  // One clock: drive SDO for the coming edge, clock, update model, check at negedge.
  task automatic tick();
    int e;
    int j;
    int t;
    bit idle;
    bit e_cnv, e_sck, e_busy, e_dv;
    e = edge_no + 1;
    for (int i = 0; i < NCH; i++) adc_sdo[i] = 1'($urandom_range(0, 1));
    if (active && e > s0 && e <= dv_e) begin
      j = (e - s0 + dd) / (2 * (dd + 1));   // number of SCK falls before edge e
      if (j < NBITS)
        for (int i = 0; i < NCH; i++) adc_sdo[i] = frame_w[i][NBITS-1-j];
    end
    @(posedge clk);
    edge_no = e;
    idle = !active || (e > dv_e);
    if (clear_stats) exp_drop = 0;
    else if (trigger && enable && !idle && exp_drop < 65535) exp_drop++;
    if (trigger && enable && idle) begin
      active = 1;
      ks     = e;
      dd     = int'(sclk_div);
      s0     = ks + 1 + CH + CC;
      dv_e   = s0 + 2 * NBITS * (dd + 1);
      for (int i = 0; i < NCH; i++) frame_w[i] = lane_w[i];
`ifdef ADC_TEST_PATTERN_EN
      frame_tm = test_mode;
`else
      frame_tm = 0;
`endif
    end
    if (active && e == dv_e) begin
      for (int i = 0; i < NCH; i++)
        exp_data[i*NBITS +: NBITS] = frame_tm ? NBITS'(fcnt + NBITS'(i)) : frame_w[i];
      fcnt = fcnt + NBITS'(1);
    end
    t      = e - s0;
    e_cnv  = active && (e >= ks + 1) && (e <= ks + CH);
    e_busy = model_busy(e);
    e_dv   = active && (e == dv_e);
    e_sck  = active && (t >= 0) && (t < 2 * NBITS * (dd + 1)) && ((t % (2 * (dd + 1))) < dd + 1);
    @(negedge clk);
    chk("adc_cnv", DW'(adc_cnv), DW'(e_cnv));
    chk("adc_sck", DW'(adc_sck), DW'(e_sck));
    chk("busy", DW'(busy), DW'(e_busy));
    chk("data_valid", DW'(data_valid), DW'(e_dv));
    chk("data_out", data_out, exp_data);
    chk("trig_drop_cnt", DW'(trig_drop_cnt), DW'(16'(exp_drop)));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    active = 0; exp_data = '0; exp_drop = 0; fcnt = '0;
    chk("rst adc_cnv", DW'(adc_cnv), DW'(1'b0));
    chk("rst adc_sck", DW'(adc_sck), DW'(1'b0));
    chk("rst busy", DW'(busy), DW'(1'b0));
    chk("rst data_valid", DW'(data_valid), DW'(1'b0));
    chk("rst data_out", data_out, exp_data);
    chk("rst trig_drop_cnt", DW'(trig_drop_cnt), DW'(16'd0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run until the model frame is over; sclk_div wiggles to prove it is latched.
  task automatic finish_frame();
    int n;
    n = 0;
    trigger = 1'b0;
    while (model_busy(edge_no + 1) || model_busy(edge_no)) begin
      sclk_div = 8'($urandom_range(0, 255));
      tick();
      n++;
      if (n > 20000) begin
        errors++;
        $display("FAIL frame_timeout: still busy after %0d cycles, required idle", n);
        break;
      end
    end
  endtask

  task automatic run_frame(input int div, input bit randw);
    for (int i = 0; i < NCH; i++)
      lane_w[i] = randw ? NBITS'($urandom) : lane_w[i];
    sclk_div = 8'(div);
    trigger  = 1'b1;
    tick();
    finish_frame();
    tick();
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b1; trigger = 1'b0; clear_stats = 1'b0;
    sclk_div = 8'd1; adc_sdo = '0;
`ifdef ADC_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    for (int i = 0; i < NCH; i++) lane_w[i] = NBITS'(16'hA5A0 + i);
    #2;
    do_reset();

    // Directed frame: sclk_div=1, lane i = A5A0+i
    run_frame(1, 0);
    // sclk_div=0, all lanes high
    for (int i = 0; i < NCH; i++) lane_w[i] = '1;
    run_frame(0, 0);

    // Randomized frames with random gaps, disabled triggers in the gaps
    for (int f = 0; f < 8; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 5)); g++) begin
        enable  = 1'b0;
        trigger = 1'($urandom_range(0, 1));
        tick();
      end
      enable = 1'b1;
      run_frame(int'($urandom_range(0, 3)), 1);
    end

    // Continuous triggering; every trigger while busy is counted
    sclk_div = 8'd1;
    lane_w[0] = 16'h1234;
    trigger = 1'b1;
    for (int n = 0; n < 196; n++) tick();
    trigger = 1'b0;
    finish_frame();
    tick();
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    // Clear with a concurrent drop wins
    trigger = 1'b1; tick();
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    tick();
    finish_frame();
    tick();

    // Reset while SCK is high during bit 7, then a clean frame
    for (int i = 0; i < NCH; i++) lane_w[i] = NBITS'($urandom);
    sclk_div = 8'd1; trigger = 1'b1; tick(); trigger = 1'b0;
    while (edge_no < s0 + 7 * 2 * (dd + 1)) tick();
    do_reset();
    run_frame(1, 1);

    // enable=0 with trigger: nothing happens
    enable = 1'b0; trigger = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    trigger = 1'b0; enable = 1'b1;
    // enable dropped mid-WAIT: frame still completes
    for (int i = 0; i < NCH; i++) lane_w[i] = NBITS'($urandom);
    sclk_div = 8'd2; trigger = 1'b1; tick(); trigger = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    enable = 1'b0;
    finish_frame();
    tick();
    enable = 1'b1;

`ifdef ADC_TEST_PATTERN_EN
    do_reset();
    test_mode = 1'b1;
    for (int f = 0; f < 3; f++) run_frame(0, 1);
    test_mode = 1'b0;
    run_frame(0, 1);
    test_mode = 1'b1;
    run_frame(0, 1);
    test_mode = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
